// File: rtl/sprite_rom_arbiter_if.sv
// Bundle between the two fighter draw units, the shared sprite colour mapper and the arbiter.
// The slave modport is the arbiter's view; the master modport is the requester/mapper side.
interface sprite_rom_arbiter_if #(
  parameter int ADDR_W = 19
);
  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic              gnt0;
  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic              gnt1;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        map_red;
  logic [7:0]        map_green;
  logic [7:0]        map_blue;
  logic              map_zero;
  logic              rd_valid0;
  logic              rd_valid1;
  logic [7:0]        rd_red;
  logic [7:0]        rd_green;
  logic [7:0]        rd_blue;
  logic              rd_zero;
  logic              busy;

  modport slave (
    input  req0, addr0, req1, addr1,
    input  map_red, map_green, map_blue, map_zero,
    output gnt0, gnt1, rom_addr,
    output rd_valid0, rd_valid1, rd_red, rd_green, rd_blue, rd_zero, busy
  );

  modport master (
    output req0, addr0, req1, addr1,
    output map_red, map_green, map_blue, map_zero,
    input  gnt0, gnt1, rom_addr,
    input  rd_valid0, rd_valid1, rd_red, rd_green, rd_blue, rd_zero, busy
  );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Round-robin sharing of one sprite colour-mapper read port between two draw units,
// with a tag pipe that routes each mapper result back to the requester that issued it.
module sprite_rom_arbiter #(
  parameter int ADDR_W  = 19,
  parameter int LATENCY = 2
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  sprite_rom_arbiter_if.slave  bus
);
  // rom_addr is itself a register, so the mapper output is valid LATENCY clocks after
  // the accept edge and is captured one edge later: the tag pipe needs LATENCY+1 stages.
  localparam int DEPTH = LATENCY + 1;

  logic              gnt0;
  logic              gnt1;
  logic              last_gnt_q,  last_gnt_d;
  logic [ADDR_W-1:0] rom_addr_q,  rom_addr_d;
  logic [DEPTH-1:0]  tag_vld_q,   tag_vld_d;
  logic [DEPTH-1:0]  tag_own_q,   tag_own_d;
  logic              rd_valid0_q, rd_valid0_d;
  logic              rd_valid1_q, rd_valid1_d;
  logic [7:0]        rd_red_q,    rd_red_d;
  logic [7:0]        rd_green_q,  rd_green_d;
  logic [7:0]        rd_blue_q,   rd_blue_d;
  logic              rd_zero_q,   rd_zero_d;

  // On a tie the requester that did not win last time gets the port.
  always_comb begin
    gnt0 = Reset_n & bus.req0 & (~bus.req1 | last_gnt_q);
    gnt1 = Reset_n & bus.req1 & (~bus.req0 | ~last_gnt_q);
  end

  always_comb begin
    last_gnt_d  = last_gnt_q;
    rom_addr_d  = rom_addr_q;
    rd_red_d    = rd_red_q;
    rd_green_d  = rd_green_q;
    rd_blue_d   = rd_blue_q;
    rd_zero_d   = rd_zero_q;
    rd_valid0_d = 1'b0;
    rd_valid1_d = 1'b0;

    if (gnt0) begin
      rom_addr_d = bus.addr0;
      last_gnt_d = 1'b0;
    end else if (gnt1) begin
      rom_addr_d = bus.addr1;
      last_gnt_d = 1'b1;
    end

    tag_vld_d = {tag_vld_q[DEPTH-2:0], gnt0 | gnt1};
    tag_own_d = {tag_own_q[DEPTH-2:0], gnt1};

    if (tag_vld_q[DEPTH-1]) begin
      rd_red_d    = bus.map_red;
      rd_green_d  = bus.map_green;
      rd_blue_d   = bus.map_blue;
      rd_zero_d   = bus.map_zero;
      rd_valid0_d = ~tag_own_q[DEPTH-1];
      rd_valid1_d = tag_own_q[DEPTH-1];
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      last_gnt_q  <= 1'b1;
      rom_addr_q  <= '0;
      tag_vld_q   <= '0;
      tag_own_q   <= '0;
      rd_valid0_q <= 1'b0;
      rd_valid1_q <= 1'b0;
      rd_red_q    <= '0;
      rd_green_q  <= '0;
      rd_blue_q   <= '0;
      rd_zero_q   <= 1'b0;
    end else begin
      last_gnt_q  <= last_gnt_d;
      rom_addr_q  <= rom_addr_d;
      tag_vld_q   <= tag_vld_d;
      tag_own_q   <= tag_own_d;
      rd_valid0_q <= rd_valid0_d;
      rd_valid1_q <= rd_valid1_d;
      rd_red_q    <= rd_red_d;
      rd_green_q  <= rd_green_d;
      rd_blue_q   <= rd_blue_d;
      rd_zero_q   <= rd_zero_d;
    end
  end

  assign bus.gnt0      = gnt0;
  assign bus.gnt1      = gnt1;
  assign bus.rom_addr  = rom_addr_q;
  assign bus.rd_valid0 = rd_valid0_q;
  assign bus.rd_valid1 = rd_valid1_q;
  assign bus.rd_red    = rd_red_q;
  assign bus.rd_green  = rd_green_q;
  assign bus.rd_blue   = rd_blue_q;
  assign bus.rd_zero   = rd_zero_q;
  assign bus.busy      = |tag_vld_q;
endmodule
